// File: rtl/barrido_funcion_ctrl.sv
// Sweep controller: steps a 5-input function through all 32 vectors, captures F into a
// truth table and counts mismatches against EXPECTED. Define STOP_ON_ERR_EN to end on the first mismatch.
`timescale 1ns/1ps

module barrido_funcion_ctrl #(
  parameter int unsigned  SETTLE   = 1,
  parameter logic [31:0]  EXPECTED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        f_in,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        K,
  output logic        M,
  output logic        busy,
  output logic        done,
  output logic [31:0] tabla,
  output logic [5:0]  err_count,
  output logic        error,
  output logic [4:0]  fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [4:0] idx;
  logic [7:0] settle_cnt;
  logic       settle_last;
  logic       mismatch;
  logic       sweep_end;

  assign settle_last = (settle_cnt == SETTLE_LAST);
  assign mismatch    = (f_in != EXPECTED[idx]);

`ifdef STOP_ON_ERR_EN
  assign sweep_end = (idx == 5'd31) || mismatch;
`else
  assign sweep_end = (idx == 5'd31);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default assigned before the case so every path drives state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = APPLY;
      APPLY:   if (settle_last) state_nx = SAMPLE;
      SAMPLE:  state_nx = sweep_end ? DONE : APPLY;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Vector index, settle counter and results; the vector stays on the last index while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
      idx        <= '0;
      settle_cnt <= '0;
      tabla      <= '0;
      err_count  <= '0;
      fail_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            tabla      <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
          end
        end
        APPLY: begin
          settle_cnt <= settle_cnt + 8'd1;
        end
        SAMPLE: begin
          tabla[idx] <= f_in;
          if (mismatch) begin
            err_count <= err_count + 6'd1;
            if (err_count == 6'd0) fail_idx <= idx;
          end
          if (!sweep_end) begin
            idx        <= idx + 5'd1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign {X, Y, Z, K, M} = idx;
  assign busy  = (state == APPLY) || (state == SAMPLE);
  assign done  = (state == DONE);
  assign error = (err_count != 6'd0);

endmodule

// File: tb/tb_barrido_funcion_ctrl.sv
// Self-checking bench for barrido_funcion_ctrl: two instances (patterned f_in and a
// sum-of-products reference function) checked against a queued reference model.
`timescale 1ns/1ps

module tb_barrido_funcion_ctrl;

  localparam int          SA    = 1;
  localparam int          SB    = 3;
  localparam logic [31:0] EXP_A = 32'hAAAA_AAAA;
`ifdef STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // Reference sum-of-products: Y'K' + X Z' M + Y Z M'
  function automatic logic fn(input logic [4:0] v);
    return (~v[3] & ~v[1]) | (v[4] & ~v[2] & v[0]) | (v[3] & v[2] & ~v[0]);
  endfunction

  function automatic logic [31:0] fn_table();
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) t[i] = fn(5'(i));
    return t;
  endfunction

  localparam logic [31:0] EXP_B = fn_table();

  typedef struct {
    logic [31:0] tabla;
    logic [5:0]  err;
    logic [4:0]  fail;
    logic [4:0]  last;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   mode = 0;
  bit   sel_b = 1'b0;

  logic        a_f, a_x, a_y, a_z, a_k, a_m, a_busy, a_done, a_error;
  logic [31:0] a_tabla;
  logic [5:0]  a_err;
  logic [4:0]  a_fail;
  logic        b_f, b_x, b_y, b_z, b_k, b_m, b_busy, b_done, b_error;
  logic [31:0] b_tabla;
  logic [5:0]  b_err;
  logic [4:0]  b_fail;

  always #5 clk = ~clk;

  always_comb begin
    a_f = 1'b0;
    case (mode)
      0: a_f = a_m;
      1: a_f = ~a_m;
      2: a_f = 1'b1;
      default: a_f = 1'b0;
    endcase
  end
  assign b_f = fn({b_x, b_y, b_z, b_k, b_m});

  barrido_funcion_ctrl #(.SETTLE(SA), .EXPECTED(EXP_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .f_in(a_f),
    .X(a_x), .Y(a_y), .Z(a_z), .K(a_k), .M(a_m),
    .busy(a_busy), .done(a_done), .tabla(a_tabla),
    .err_count(a_err), .error(a_error), .fail_idx(a_fail)
  );

  barrido_funcion_ctrl #(.SETTLE(SB), .EXPECTED(EXP_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .f_in(b_f),
    .X(b_x), .Y(b_y), .Z(b_z), .K(b_k), .M(b_m),
    .busy(b_busy), .done(b_done), .tabla(b_tabla),
    .err_count(b_err), .error(b_error), .fail_idx(b_fail)
  );

  logic        o_busy, o_done, o_error;
  logic [31:0] o_tabla;
  logic [5:0]  o_err;
  logic [4:0]  o_fail, o_vec;
  always_comb begin
    o_busy  = sel_b ? b_busy  : a_busy;
    o_done  = sel_b ? b_done  : a_done;
    o_error = sel_b ? b_error : a_error;
    o_tabla = sel_b ? b_tabla : a_tabla;
    o_err   = sel_b ? b_err   : a_err;
    o_fail  = sel_b ? b_fail  : a_fail;
    o_vec   = sel_b ? {b_x, b_y, b_z, b_k, b_m} : {a_x, a_y, a_z, a_k, a_m};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mode_table(input int md);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      case (md)
        0: t[i] = i[0];
        1: t[i] = ~i[0];
        2: t[i] = 1'b1;
        default: t[i] = 1'b0;
      endcase
    end
    return t;
  endfunction

  // Reference model: walk the vectors in order, stop early only in stop-on-error builds.
  task automatic model_push(input logic [31:0] ftab, input logic [31:0] exp, input int settle);
    exp_t e;
    e.tabla = '0;
    e.err   = '0;
    e.fail  = '0;
    e.last  = 5'd31;
    for (int i = 0; i < 32; i++) begin
      e.tabla[i] = ftab[i];
      if (ftab[i] != exp[i]) begin
        if (e.err == 6'd0) e.fail = 5'(i);
        e.err = e.err + 6'd1;
        if (STOP) begin
          e.last = 5'(i);
          break;
        end
      end
    end
    e.lat = 1 + (int'(e.last) + 1) * (settle + 1);
    sb.push_back(e);
  endtask

  task automatic run_sweep(input string name, input bit use_b, input bit pulse_mid, input bit hold);
    exp_t e;
    int   k;
    int   budget;
    sel_b = use_b;
    if (use_b) model_push(EXP_B, EXP_B, SB);
    else       model_push(mode_table(mode), EXP_A, SA);
    budget = sb[0].lat + 20;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    for (k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, "_busy_first"}, 32'(o_busy), 32'd1);
        check({name, "_vec_first"}, 32'(o_vec), 32'd0);
      end
      if (pulse_mid && k == 10) start_a = 1'b1;
      if (pulse_mid && k == 11) start_a = 1'b0;
      if (o_done) break;
    end
    e = sb.pop_front();
    check({name, "_latency"}, 32'(k), 32'(e.lat));
    check({name, "_tabla"}, o_tabla, e.tabla);
    check({name, "_err"}, 32'(o_err), 32'(e.err));
    check({name, "_error"}, 32'(o_error), 32'(e.err != 6'd0));
    check({name, "_fail"}, 32'(o_fail), 32'(e.fail));
    check({name, "_busy_done"}, 32'(o_busy), 32'd0);
    check({name, "_vec_last"}, 32'(o_vec), 32'(e.last));
    @(negedge clk);
    check({name, "_busy_idle"}, 32'(o_busy), 32'd0);
    check({name, "_tabla_hold"}, o_tabla, e.tabla);
    if (hold) begin
      @(negedge clk);
      check({name, "_restart_busy"}, 32'(o_busy), 32'd1);
      check({name, "_restart_vec"}, 32'(o_vec), 32'd0);
      check({name, "_restart_clr"}, 32'(o_err), 32'd0);
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  initial begin
    int  n;
    bool_found: begin end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_tabla", a_tabla, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_error", 32'(a_error), 32'd0);
    check("rst_fail", 32'(a_fail), 32'd0);
    check("rst_vec", 32'({a_x, a_y, a_z, a_k, a_m}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mode = 0; run_sweep("m_clean", 1'b0, 1'b0, 1'b0);
    mode = 1; run_sweep("not_m", 1'b0, 1'b0, 1'b0);
    mode = 2; run_sweep("ones", 1'b0, 1'b0, 1'b0);
    mode = 3; run_sweep("zeros", 1'b0, 1'b0, 1'b0);
    mode = 0; run_sweep("pulse_busy", 1'b0, 1'b1, 1'b0);

    run_sweep("func", 1'b1, 1'b0, 1'b0);
    check("func_t0", 32'(b_tabla[0]), 32'd1);
    check("func_t31", 32'(b_tabla[31]), 32'd0);

    mode = 0; run_sweep("held", 1'b0, 1'b0, 1'b1);

    // The restarted sweep is interrupted by reset while vector 10 is applied.
    sel_b = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_busy && {a_x, a_y, a_z, a_k, a_m} == 5'd10) break;
    end
    check("mid_reach_idx10", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_vec", 32'({a_x, a_y, a_z, a_k, a_m}), 32'd0);
    check("mid_rst_tabla", a_tabla, 32'd0);
    @(negedge clk);
    check("mid_rst_done", 32'(a_done), 32'd0);
    check("mid_rst_err", 32'(a_err), 32'd0);
    check("mid_rst_fail", 32'(a_fail), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_idle", 32'(a_busy), 32'd0);
    mode = 0; run_sweep("after_rst", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
